// File: rtl/add_round_key_bank.sv
// AddRoundKey engine: a bank of ROUNDS+1 round keys, one XOR per accepted state,
// and results returned through a 2-entry output/skid buffer.
module add_round_key_bank #(
  parameter  int DATA_W = 128,
  parameter  int ROUNDS = 10,
  localparam int IDX_W  = $clog2(ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [IDX_W-1:0]  in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_state,
  output logic [IDX_W-1:0]  out_round,
  output logic              out_err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS);

  typedef struct packed {
    logic [DATA_W-1:0] state;
    logic [IDX_W-1:0]  round;
    logic              err;
  } word_t;

  logic [DATA_W-1:0] r_key [ROUNDS+1];
  logic [ROUNDS:0]   r_loaded;
  word_t             r_out, r_skid;
  logic              r_out_vld, r_skid_vld;
  word_t             w_new;
  logic              w_acc, w_fire, w_wr_ok;

  assign w_acc   = in_valid && !r_skid_vld;
  assign w_fire  = r_out_vld && out_ready;
  assign w_wr_ok = key_wr_en && (key_wr_idx <= LAST);

  // The err term short-circuits before the loaded bit is looked at for illegal rounds.
  always_comb begin
    w_new       = '0;
    w_new.round = in_round;
    w_new.err   = (in_round > LAST) || !r_loaded[in_round];
    w_new.state = w_new.err ? in_state : (in_state ^ r_key[in_round]);
  end

  // Key bank: registered reads of this cycle see the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= ROUNDS; i++) r_key[i] <= '0;
      r_loaded <= '0;
    end else if (w_wr_ok) begin
      r_key[key_wr_idx]    <= key_wr_data;
      r_loaded[key_wr_idx] <= 1'b1;
    end
  end

  // While SKID is full in_ready is low, so no accept competes with its drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (r_skid_vld) begin
      if (w_fire) begin
        r_out      <= r_skid;
        r_skid_vld <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_out_vld || out_ready) begin
        r_out     <= w_new;
        r_out_vld <= 1'b1;
      end else begin
        r_skid     <= w_new;
        r_skid_vld <= 1'b1;
      end
    end else if (w_fire) begin
      r_out_vld <= 1'b0;
    end
  end

  assign in_ready  = !r_skid_vld;
  assign out_valid = r_out_vld;
  assign out_state = r_out.state;
  assign out_round = r_out.round;
  assign out_err   = r_out.err;

endmodule

// File: tb/tb_add_round_key_bank.sv
// Scoreboard bench for add_round_key_bank: ROUNDS=10 instance for the main flow,
// a ROUNDS=14 instance for the reset-mid-stream case.
module tb_add_round_key_bank;

  typedef struct packed {
    logic [127:0] st;
    logic [3:0]   rd;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, key_wr_en, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]   key_wr_idx, in_round, out_round;
  logic [127:0] key_wr_data, in_state, out_state;

  logic         reset_b, key_wr_en_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_err_b;
  logic [3:0]   key_wr_idx_b, in_round_b, out_round_b;
  logic [127:0] key_wr_data_b, in_state_b, out_state_b;

  int n_chk = 0;
  int n_err = 0;
  exp_t q[$];
  logic [127:0] m_key [16];
  logic         m_ld  [16];

  always #5 clk = ~clk;

  add_round_key_bank #(.DATA_W(128), .ROUNDS(10)) dut (
    .clk(clk), .reset(reset), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_round(in_round), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .out_round(out_round), .out_err(out_err)
  );

  add_round_key_bank #(.DATA_W(128), .ROUNDS(14)) dut14 (
    .clk(clk), .reset(reset_b), .key_wr_en(key_wr_en_b), .key_wr_idx(key_wr_idx_b),
    .key_wr_data(key_wr_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_state(in_state_b), .in_round(in_round_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_state(out_state_b), .out_round(out_round_b), .out_err(out_err_b)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: occupancy invariants, pop on output handshake, push on accept,
  // then apply key writes so a same-edge accept uses the old key.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      for (int i = 0; i < 16; i++) begin m_key[i] = '0; m_ld[i] = 1'b0; end
    end else begin
      chk("occ_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("occ_ready", 128'(in_ready), 128'(q.size() < 2));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_underflow", 128'(1), 128'(0));
        else begin
          e = q.pop_front();
          chk("sb_state", out_state, e.st);
          chk("sb_round", 128'(out_round), 128'(e.rd));
          chk("sb_err", 128'(out_err), 128'(e.err));
        end
      end
      if (in_valid && in_ready) begin
        e.rd  = in_round;
        e.err = (in_round > 4'd10) || !m_ld[in_round];
        e.st  = e.err ? in_state : (in_state ^ m_key[in_round]);
        q.push_back(e);
      end
      if (key_wr_en && key_wr_idx <= 4'd10) begin
        m_key[key_wr_idx] = key_wr_data;
        m_ld[key_wr_idx]  = 1'b1;
      end
    end
  end

  task automatic wr_key(input logic [3:0] idx, input logic [127:0] k);
    key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = k;
    @(posedge clk); #1;
    key_wr_en = 1'b0;
  endtask

  task automatic send(input logic [127:0] st, input logic [3:0] rd);
    logic a;
    int   n;
    in_valid = 1'b1; in_state = st; in_round = rd;
    n = 0;
    do begin
      a = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!a && n < 100);
    if (!a) chk("send_timeout", 128'(0), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [127:0] s, k1, k2;
    logic         a;
    int           k, sent, cyc;
    reset = 1'b1; key_wr_en = 0; key_wr_idx = 0; key_wr_data = 0;
    in_valid = 0; in_state = 0; in_round = 0; out_ready = 1'b1;
    reset_b = 1'b1; key_wr_en_b = 0; key_wr_idx_b = 0; key_wr_data_b = 0;
    in_valid_b = 0; in_state_b = 0; in_round_b = 0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0; reset_b = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, 128'(0));
    chk("rst_out_round", 128'(out_round), 128'(0));
    chk("rst_out_err", 128'(out_err), 128'(0));

    // FIPS-197 round-0 key addition
    wr_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    send(128'h00112233445566778899aabbccddeeff, 4'd0);
    @(negedge clk);
    chk("fips_valid", 128'(out_valid), 128'(1));
    chk("fips_state", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("fips_err", 128'(out_err), 128'(0));

    // error paths after a fresh reset
    do_reset();
    s = rnd128();
    send(s, 4'd3);
    @(negedge clk);
    chk("err_unloaded", 128'(out_err), 128'(1));
    chk("err_unloaded_st", out_state, s);
    send(s, 4'd12);
    @(negedge clk);
    chk("err_range", 128'(out_err), 128'(1));
    chk("err_range_st", out_state, s);
    chk("err_range_rd", 128'(out_round), 128'(12));
    k1 = rnd128();
    wr_key(4'd3, k1);
    send(s, 4'd3);
    @(negedge clk);
    chk("err_cleared", 128'(out_err), 128'(0));
    chk("err_cleared_st", out_state, s ^ k1);

    // same-edge rewrite: first S sees K1, second sees K2
    k1 = rnd128(); k2 = rnd128(); s = rnd128();
    wr_key(4'd2, k1);
    key_wr_en = 1'b1; key_wr_idx = 4'd2; key_wr_data = k2;
    send(s, 4'd2);
    key_wr_en = 1'b0;
    @(negedge clk);
    chk("rw_old_key", out_state, s ^ k1);
    send(s, 4'd2);
    @(negedge clk);
    chk("rw_new_key", out_state, s ^ k2);

    // streaming with random stalls
    for (int i = 0; i <= 10; i++) wr_key(4'(i), rnd128());
    sent = 0; cyc = 0;
    while (sent < 200 && cyc < 5000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_state  = rnd128();
      in_round  = 4'($urandom_range(0, 10));
      out_ready = ($urandom_range(0, 3) != 0);
      a = in_valid && in_ready;
      @(posedge clk); #1;
      if (a) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_sent", 128'(sent), 128'(200));
    repeat (4) @(posedge clk); #1;
    chk("stream_drained", 128'(q.size()), 128'(0));

    // backpressure: 3 offered, 2 held, then ordered drain
    out_ready = 1'b0; k = 0;
    in_valid = 1'b1; in_state = rnd128(); in_round = 4'd5;
    for (int c = 0; c < 6; c++) begin
      a = in_ready;
      @(posedge clk); #1;
      if (a) begin
        k++;
        in_state = rnd128(); in_round = 4'(5 + k);
      end
    end
    chk("bp_accepted", 128'(k), 128'(2));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1; cyc = 0;
    while (k < 3 && cyc < 20) begin
      a = in_ready;
      @(posedge clk); #1;
      if (a) k++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_third", 128'(k), 128'(3));
    repeat (4) @(posedge clk); #1;
    chk("bp_drained", 128'(q.size()), 128'(0));

    // ROUNDS=14: reset with two words buffered
    key_wr_en_b = 1'b1; key_wr_idx_b = 4'd14; key_wr_data_b = rnd128();
    @(posedge clk); #1;
    key_wr_en_b = 1'b0;
    out_ready_b = 1'b0;
    chk("r14_ready0", 128'(in_ready_b), 128'(1));
    in_valid_b = 1'b1; in_state_b = rnd128(); in_round_b = 4'd14;
    @(posedge clk); #1;
    in_state_b = rnd128();
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("r14_full_ready", 128'(in_ready_b), 128'(0));
    chk("r14_full_valid", 128'(out_valid_b), 128'(1));
    chk("r14_loaded_err", 128'(out_err_b), 128'(0));
    reset_b = 1'b1;
    @(posedge clk); #1;
    reset_b = 1'b0;
    @(negedge clk);
    chk("r14_rst_valid", 128'(out_valid_b), 128'(0));
    chk("r14_rst_ready", 128'(in_ready_b), 128'(1));
    out_ready_b = 1'b1;
    s = rnd128();
    in_valid_b = 1'b1; in_state_b = s; in_round_b = 4'd14;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("r14_post_valid", 128'(out_valid_b), 128'(1));
    chk("r14_post_err", 128'(out_err_b), 128'(1));
    chk("r14_post_state", out_state_b, s);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
